// File: rtl/seg_pkg.sv
// seg_pkg
// Shared types and constants for the seven-segment scan driver.
// A seg_t holds one digit pattern: index 0 is segment a, index 6 is segment g,
// and every segment is active-low (0 lights the segment).
package seg_pkg;

    typedef logic [0:6] seg_t;

    // Every segment off. Used for reset, guard intervals and blanked digits.
    localparam seg_t SEG_BLANK = 7'b1111111;
    // The pattern for the digit 0. Leading-zero blanking compares against it.
    localparam seg_t SEG_ZERO  = 7'b0000001;

    // Decimal digit patterns as produced by the upstream decoder.
    localparam seg_t SEG_D0 = 7'b0000001;
    localparam seg_t SEG_D1 = 7'b1001111;
    localparam seg_t SEG_D2 = 7'b0010010;
    localparam seg_t SEG_D3 = 7'b0000110;
    localparam seg_t SEG_D4 = 7'b1001100;
    localparam seg_t SEG_D5 = 7'b0100100;
    localparam seg_t SEG_D6 = 7'b0100000;
    localparam seg_t SEG_D7 = 7'b0001111;
    localparam seg_t SEG_D8 = 7'b0000000;
    localparam seg_t SEG_D9 = 7'b0000100;

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if
// Bundles the decoder-facing inputs and the display-facing outputs of
// seg_scan_mux.
//   seg_in1..seg_in4 : units..thousands patterns from the decoder (active-low)
//   load             : one-cycle strobe capturing all four patterns
//   seg              : shared segment bus (active-low)
//   an               : anode enables, active-low, an[0] = units
//   upd_ack          : one-cycle pulse when new patterns reach the display
// master = the side feeding patterns, slave = the scan driver itself.
interface seg_scan_mux_if;
    import seg_pkg::*;

    seg_t       seg_in1;
    seg_t       seg_in2;
    seg_t       seg_in3;
    seg_t       seg_in4;
    logic       load;
    seg_t       seg;
    logic [3:0] an;
    logic       upd_ack;

    modport master (
        output seg_in1, seg_in2, seg_in3, seg_in4, load,
        input  seg, an, upd_ack
    );

    modport slave (
        input  seg_in1, seg_in2, seg_in3, seg_in4, load,
        output seg, an, upd_ack
    );

endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer
// Digit-slot timebase for the scan driver. A prescaler counts 0..DIV-1 and
// the slot index advances 0..3 each time the prescaler wraps.
//   clk, rst  : clock and synchronous active-high reset
//   idx       : current digit slot (0 = units)
//   guard     : high during the first GUARD cycles of each slot
//   frame_end : high on the last cycle of slot 3 (frame boundary)
module seg_scan_timer #(
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       guard,
    output logic       frame_end
);

    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);

    logic [PRE_W-1:0] pre;

    // Prescaler and slot index. The slot index is two bits wide, so it
    // wraps from 3 back to 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + PRE_ONE;
        end
    end

    assign guard     = (pre < GUARD_END);
    assign frame_end = (pre == PRE_LAST) && (idx == 2'd3);

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexed driver for a four-digit common-anode seven-segment
// display. Patterns are captured into a staging register on load and copied
// into the displayed shadow register only at a frame boundary, so a frame
// never mixes old and new digits.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seg_scan_mux_if slave (seg_in1..4, load in; seg, an, upd_ack out)
// Parameters: DIV cycles per digit slot, GUARD all-off cycles at the start of
// each slot, BLANK_LZ enables leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIV      = 50000,
    parameter int GUARD    = 16,
    parameter int BLANK_LZ = 1
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave bus
);

    logic [1:0] idx;
    logic       guard;
    logic       frame_end;

    seg_scan_timer #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .guard     (guard),
        .frame_end (frame_end)
    );

    // Element 0 is units, element 3 is thousands, matching an[0]..an[3].
    seg_t [3:0] seg_in_all;
    seg_t [3:0] staging;
    seg_t [3:0] shadow;
    logic       pending;
    logic       commit;

    assign seg_in_all = {bus.seg_in4, bus.seg_in3, bus.seg_in2, bus.seg_in1};

    // A commit happens at the frame boundary if anything is waiting, either
    // in staging or arriving on this very cycle.
    assign commit = frame_end && (pending || bus.load);

    // Staging and shadow. A load on the boundary cycle goes straight into
    // the shadow so the freshest patterns win and only one ack is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= {4{SEG_BLANK}};
            shadow  <= {4{SEG_BLANK}};
            pending <= 1'b0;
        end else if (commit) begin
            shadow  <= bus.load ? seg_in_all : staging;
            pending <= 1'b0;
        end else if (bus.load) begin
            staging <= seg_in_all;
            pending <= 1'b1;
        end
    end

    logic [3:0] blank;

    // A digit is dark when its pattern is already all-off (nothing to show,
    // so the anode stays off too) or when leading-zero blanking removes it.
    // Units can only go dark through the first rule.
    always_comb begin
        blank = '0;
        for (int k = 0; k < 4; k++) begin
            if (shadow[k] == SEG_BLANK) begin
                blank[k] = 1'b1;
            end
        end
        if (BLANK_LZ != 0) begin
            if (shadow[3] == SEG_ZERO) begin
                blank[3] = 1'b1;
            end
            if ((shadow[3] == SEG_ZERO) && (shadow[2] == SEG_ZERO)) begin
                blank[2] = 1'b1;
            end
            if ((shadow[3] == SEG_ZERO) && (shadow[2] == SEG_ZERO) &&
                (shadow[1] == SEG_ZERO)) begin
                blank[1] = 1'b1;
            end
        end
    end

    seg_t       seg_next;
    logic [3:0] an_next;

    // Drive for the current slot: dark during the guard interval to stop the
    // previous digit ghosting into this one, otherwise one anode low.
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = 4'b1111;
        if (!guard && !blank[idx]) begin
            an_next[idx] = 1'b0;
            seg_next     = shadow[idx];
        end
    end

    seg_t       seg_q;
    logic [3:0] an_q;
    logic       ack_q;

    // Output registers give a glitch-free display bus and a fixed one-cycle
    // latency from the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'b1111;
            ack_q <= 1'b0;
        end else begin
            seg_q <= seg_next;
            an_q  <= an_next;
            ack_q <= commit;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.upd_ack = ack_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
// Self-checking bench for seg_scan_mux with DIV=8, GUARD=2, BLANK_LZ=1.
// A cycle-level model derives the expected display from the cycle count and
// the load history; hand-written literal expectations pin key cycles.
module tb_seg_scan_mux;
    import seg_pkg::*;

    localparam int DIV   = 8;
    localparam int GUARD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_mux_if bus ();

    seg_scan_mux #(
        .DIV      (DIV),
        .GUARD    (GUARD),
        .BLANK_LZ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Cycle number since reset release; cycle 0 is the first cycle with rst low.
    int cyc = 0;

    // Model state: digit 0 is units, digit 3 is thousands.
    seg_t       m_shadow [4];
    seg_t       m_staging[4];
    bit         m_pending;
    bit         model_valid = 0;
    int         m_pre;
    int         m_slot;
    bit         m_boundary;
    logic [3:0] exp_an;
    seg_t       exp_seg;
    logic       exp_ack;

    // What the display must show for a given slot and position in the slot:
    // count leading zeros from thousands downward (never counting units),
    // digits inside that run are dark, as is any digit with nothing lit.
    function automatic void expectedDrive(input int slot, input int pre,
                                          output logic [3:0] an, output seg_t s);
        int lz;
        bit in_run;
        an     = 4'b1111;
        s      = SEG_BLANK;
        lz     = 0;
        in_run = 1;
        for (int k = 3; k >= 1; k--) begin
            if (in_run && m_shadow[k] == SEG_ZERO) lz++;
            else in_run = 0;
        end
        if (pre >= GUARD && slot < 4 - lz && m_shadow[slot] != SEG_BLANK) begin
            an = ~(4'b0001 << slot);
            s  = m_shadow[slot];
        end
    endfunction

    // Model step: expected outputs for the next cycle come from this cycle's
    // position in the frame and the patterns on display; loads are queued and
    // the latest queued set is shown from the next frame boundary.
    always @(posedge clk) begin
        if (rst) begin
            cyc       = 0;
            m_pending = 0;
            for (int k = 0; k < 4; k++) begin
                m_shadow[k]  = SEG_BLANK;
                m_staging[k] = SEG_BLANK;
            end
            exp_an      = 4'b1111;
            exp_seg     = SEG_BLANK;
            exp_ack     = 1'b0;
            model_valid = 1;
        end else begin
            m_pre      = cyc % DIV;
            m_slot     = (cyc / DIV) % 4;
            expectedDrive(m_slot, m_pre, exp_an, exp_seg);
            m_boundary = (m_pre == DIV - 1) && (m_slot == 3);
            if (bus.load) begin
                m_staging[0] = bus.seg_in1;
                m_staging[1] = bus.seg_in2;
                m_staging[2] = bus.seg_in3;
                m_staging[3] = bus.seg_in4;
                m_pending    = 1;
            end
            exp_ack = m_boundary && m_pending;
            if (exp_ack) begin
                m_shadow  = m_staging;
                m_pending = 0;
            end
            cyc++;
        end
    end

    task automatic compareSig(input string name, input logic [6:0] act,
                              input logic [6:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            compareSig("model_an",  {3'b000, bus.an},       {3'b000, exp_an});
            compareSig("model_seg", bus.seg,                exp_seg);
            compareSig("model_ack", {6'b0, bus.upd_ack},    {6'b0, exp_ack});
        end
    end

    // Park at the negedge of cycle n, with a bound so a stuck count still ends.
    task automatic waitCycle(input int n);
        int spins = 0;
        while (cyc != n && spins < 2000) begin
            @(negedge clk);
            spins++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_cycle actual=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a load strobe for exactly the given cycle.
    task automatic applyStimulus(input int at_cycle, input seg_t th, input seg_t h,
                                 input seg_t t, input seg_t u);
        waitCycle(at_cycle);
        bus.seg_in1 = u;
        bus.seg_in2 = t;
        bus.seg_in3 = h;
        bus.seg_in4 = th;
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int at_cycle,
                               input logic [3:0] req_an, input seg_t req_seg,
                               input logic req_ack);
        waitCycle(at_cycle);
        compareSig({name, "_an"},  {3'b000, bus.an},    {3'b000, req_an});
        compareSig({name, "_seg"}, bus.seg,             req_seg);
        compareSig({name, "_ack"}, {6'b0, bus.upd_ack}, {6'b0, req_ack});
    endtask

    initial begin
        bus.seg_in1 = SEG_BLANK;
        bus.seg_in2 = SEG_BLANK;
        bus.seg_in3 = SEG_BLANK;
        bus.seg_in4 = SEG_BLANK;
        bus.load    = 1'b0;

        // Reset, then idle with nothing loaded: display stays dark.
        doReset();
        for (int i = 0; i <= 40; i++) checkOutput("idle", i, 4'b1111, SEG_BLANK, 1'b0);

        // 1234 loaded in cycle 0, committed at the first boundary.
        doReset();
        applyStimulus(0, SEG_D1, SEG_D2, SEG_D3, SEG_D4);
        checkOutput("d1234_pre", 31, 4'b1111, SEG_BLANK, 1'b0);
        checkOutput("d1234_ack", 32, 4'b1111, SEG_BLANK, 1'b1);
        checkOutput("d1234_g0",  33, 4'b1111, SEG_BLANK, 1'b0);
        checkOutput("d1234_g0",  34, 4'b1111, SEG_BLANK, 1'b0);
        for (int i = 35; i <= 40; i++) checkOutput("d1234_u", i, 4'b1110, SEG_D4, 1'b0);
        checkOutput("d1234_g1", 41, 4'b1111, SEG_BLANK, 1'b0);
        checkOutput("d1234_g1", 42, 4'b1111, SEG_BLANK, 1'b0);
        for (int i = 43; i <= 48; i++) checkOutput("d1234_t", i, 4'b1101, SEG_D3, 1'b0);

        // 0007 then 0700: leading-zero blanking.
        doReset();
        applyStimulus(0, SEG_D0, SEG_D0, SEG_D0, SEG_D7);
        checkOutput("lz7_ack",  32,  4'b1111, SEG_BLANK, 1'b1);
        checkOutput("lz7_u",    35,  4'b1110, SEG_D7,    1'b0);
        checkOutput("lz7_t",    43,  4'b1111, SEG_BLANK, 1'b0);
        checkOutput("lz7_h",    51,  4'b1111, SEG_BLANK, 1'b0);
        checkOutput("lz7_th",   59,  4'b1111, SEG_BLANK, 1'b0);
        applyStimulus(64, SEG_D0, SEG_D7, SEG_D0, SEG_D0);
        checkOutput("lz700_ack", 96,  4'b1111, SEG_BLANK, 1'b1);
        checkOutput("lz700_u",   99,  4'b1110, SEG_D0,    1'b0);
        checkOutput("lz700_t",   107, 4'b1101, SEG_D0,    1'b0);
        checkOutput("lz700_h",   115, 4'b1011, SEG_D7,    1'b0);
        checkOutput("lz700_th",  123, 4'b1111, SEG_BLANK, 1'b0);

        // Two loads in one frame: the later one wins, single ack.
        doReset();
        applyStimulus(3,  SEG_D5, SEG_D6, SEG_D7, SEG_D8);
        applyStimulus(10, SEG_D1, SEG_D2, SEG_D3, SEG_D4);
        checkOutput("two_pre",  31, 4'b1111, SEG_BLANK, 1'b0);
        checkOutput("two_ack",  32, 4'b1111, SEG_BLANK, 1'b1);
        checkOutput("two_post", 33, 4'b1111, SEG_BLANK, 1'b0);
        checkOutput("two_u",    35, 4'b1110, SEG_D4,    1'b0);
        checkOutput("two_t",    43, 4'b1101, SEG_D3,    1'b0);

        // Load on the boundary cycle: one-cycle load-to-ack.
        doReset();
        applyStimulus(31, SEG_D1, SEG_D2, SEG_D3, SEG_D4);
        checkOutput("bnd_ack", 32, 4'b1111, SEG_BLANK, 1'b1);
        checkOutput("bnd_u",   35, 4'b1110, SEG_D4,    1'b0);
        checkOutput("bnd_h",   51, 4'b1011, SEG_D2,    1'b0);
        checkOutput("bnd_th",  59, 4'b0111, SEG_D1,    1'b0);

        // Reset mid-frame discards the pending load.
        doReset();
        applyStimulus(5, SEG_D1, SEG_D2, SEG_D3, SEG_D4);
        waitCycle(20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 40; i++) checkOutput("midrst", i, 4'b1111, SEG_BLANK, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed driver for a four-digit common-anode seven-segment display. Sits directly downstream of the binary-to-BCD/seven-segment decoder: it captures the decoder's four digit patterns on a load strobe and commits them atomically at frame boundaries, so a display never shows a half-updated value. It drives one shared segment bus plus four active-low anode enables, and applies leading-zero blanking, an anti-ghosting guard interval and a one-cycle update acknowledge.

## Interface
- DIV, 50000: clock cycles per digit slot (≥ 4).
- GUARD, 16: cycles at the start of each slot with all anodes off (1 ≤ GUARD < DIV).
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- seg_in1  in  [0:6]  units pattern. Bit 0 = segment a, bit 6 = segment g, active-low.
- seg_in2  in  [0:6]  tens pattern.
- seg_in3  in  [0:6]  hundreds pattern.
- seg_in4  in  [0:6]  thousands pattern.
- load  in  1  one-cycle strobe that captures all four seg_in* patterns.
- seg  out  [0:6]  shared segment bus, active-low.
- an  out  [3:0]  anode enables, active-low. an[0] is units, an[3] is thousands.
- upd_ack  out  1  one-cycle pulse when new patterns are committed to the display.

## Operation
- **Scan timer:**
  - `pre` counts 0..DIV-1.
  - `idx` (0..3) increments when `pre` wraps.
  - `idx` wraps 3→0.
  - A frame is 4·DIV cycles.
  - The frame boundary is the cycle with `pre`==DIV-1 and `idx`==3.
- **Staging:**
  - `load`=1 writes seg_in1..4 to the staging register and sets `pending`.
  - A further load while `pending` is set overwrites staging. Last load wins.
- **Commit:**
  - At the frame boundary with `pending`=1: shadow ← staging, `pending` ← 0, and `upd_ack`=1 on the next cycle.
  - If `load`=1 on the boundary cycle itself, seg_in* bypasses staging straight into shadow. `pending` ← 0 and one `upd_ack` is issued.
  - Without `pending` or `load`, shadow holds its value and no ack is issued.
- **Blanking** (BLANK_LZ=1, computed from shadow; ZERO = 0000001):
  - Thousands is blank if it equals ZERO.
  - Hundreds is blank if hundreds and thousands are both ZERO.
  - Tens is blank if tens, hundreds and thousands are all ZERO.
  - Units is never blanked.
  - A blanked digit keeps its anode off for the whole slot (an=1111, seg=BLANK).
- **Drive for slot `idx`=k:**
  - While `pre` < GUARD: an=1111, seg=BLANK (1111111).
  - Otherwise: an has only bit k low and seg = shadow digit k, unless that digit is blanked.
- **Reset values:**
  - seg=1111111, an=1111, upd_ack=0.
  - Internally: `pre`=0, `idx`=0, shadow and staging all BLANK, `pending`=0.
- **Reset mid-operation:** all of the above is restored on the next edge. Pending data is discarded and no ack is issued for it.

## Timing
- seg, an and upd_ack are registered. They reflect the `pre`/`idx`/shadow state of the previous cycle, a fixed one-cycle latency.
- First post-reset cycle (rst low) is cycle 0 with `pre`=0, `idx`=0.
- First frame boundary is cycle 4·DIV-1.
- A commit on that edge gives upd_ack=1 in cycle 4·DIV. The committed digits appear from that cycle onward, starting with the slot-0 guard.
- Worst-case load-to-ack latency is 4·DIV cycles. Best case is 1 cycle (load on the boundary).
- upd_ack is never high for two consecutive cycles, since DIV ≥ 4.
- Exactly one anode at most is low in any cycle.

## Structure
- **Package `seg_pkg`:**
  - typedef `seg_t` = logic [0:6].
  - Constants SEG_BLANK=1111111 and SEG_ZERO=0000001.
  - Digit pattern constants for 0-9, used by the bench.
- **Sub-module `seg_scan_timer`:**
  - Contains `pre`/`idx` counters.
  - Outputs `idx`, `guard` (`pre` < GUARD) and `frame_end` (`pre`==DIV-1 && `idx`==3).
- **Top level:** staging, pending, shadow, blanking and output registers.

## Test plan
All scenarios use DIV=8, GUARD=2, BLANK_LZ=1.
- **Reset:** rst=1 for 3 cycles, then released with no loads. Expected: seg=1111111, an=1111 and upd_ack=0 for at least 40 cycles.
- **Display 1234:**
  - Stimulus: load in cycle 0 with units=1001100, tens=0000110, hundreds=0010010, thousands=1001111.
  - Expected: upd_ack=1 only in cycle 32.
  - Expected, cycles 35-40: an=1110, seg=1001100.
  - Expected, cycles 43-48: an=1101, seg=0000110.
  - Expected: guard cycles 33-34 and 41-42 show an=1111.
- **Leading-zero blanking, display 0007:**
  - Stimulus: load units=0001111, others 0000001.
  - Expected: after the ack only an=1110 ever goes low, with seg=0001111.
  - Stimulus: reload as 0700.
  - Expected: an[2] and an[1] slots active (tens shows 0000001), an[3] never active.
- **Two loads in one frame:** loads in cycles 3 and 10 with different values. Expected: a single upd_ack in cycle 32 and only the cycle-10 patterns displayed.
- **Load on boundary:** load in cycle 31 with 1234 patterns. Expected: upd_ack=1 in cycle 32 and 1234 displayed from slot 0 of the next frame.
- **Reset mid-frame:** load in cycle 5, rst=1 in cycle 20. Expected: no upd_ack ever appears for that load, and outputs stay at reset values.
